// File: rtl/quad_speed.sv
// -----------------------------------------------------------------------------
// quad_speed
//   Quadrature encoder speed meter. The A/B channels are synchronized and
//   decoded into +1/-1 steps. The steps are summed in a saturating signed
//   accumulator over a free-running window of 2^WINDOW_BITS clk cycles. At the
//   end of each window the sum is clamped to [-127,+127] and registered as
//   measuredSpeed. An illegal A/B jump (both bits changing at once) is counted
//   as 0 and reported on glitch for the whole following window.
//
// Ports
//   clk            in   system clock, all state changes on its rising edge
//   reset_n        in   asynchronous active-low reset
//   encA, encB     in   quadrature channels, asynchronous to clk
//   measuredSpeed  out  signed ticks per window, clamped to [-127,+127]
//   speedValid     out  one-cycle pulse when measuredSpeed updates
//   glitch         out  previous window contained an illegal transition
// -----------------------------------------------------------------------------
module quad_speed #(
    parameter int WINDOW_BITS = 20,
    parameter int ACC_BITS    = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              encA,
    input  logic              encB,
    output logic signed [7:0] measuredSpeed,
    output logic              speedValid,
    output logic              glitch
);

    // Symmetric saturation limits; the most negative code is never used.
    localparam logic signed [ACC_BITS-1:0] ACC_MAX  = {1'b0, {(ACC_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS-1:0] ACC_MIN  = -ACC_MAX;
    localparam logic signed [ACC_BITS-1:0] ACC_ONE  = ACC_BITS'(1);
    localparam logic signed [ACC_BITS-1:0] CLAMP_HI = ACC_BITS'(127);
    localparam logic signed [ACC_BITS-1:0] CLAMP_LO = -CLAMP_HI;

    logic                       r_a_meta;
    logic                       r_a_sync;
    logic                       r_b_meta;
    logic                       r_b_sync;
    logic [1:0]                 r_prev_ab;
    logic                       r_primed;
    logic signed [ACC_BITS-1:0] r_acc;
    logic [WINDOW_BITS-1:0]     r_win;
    logic                       r_glitch_seen;

    logic [1:0]                 w_cur_ab;
    logic                       w_inc;
    logic                       w_dec;
    logic                       w_illegal;
    logic                       w_eow;
    logic signed [ACC_BITS-1:0] w_acc_next;
    logic signed [7:0]          w_speed_clamped;

    assign w_cur_ab = {r_a_sync, r_b_sync};
    assign w_eow    = &r_win;

    // {prev, cur} decode. Nothing is counted until prevAB holds a real sample.
    always_comb begin
        w_inc     = 1'b0;
        w_dec     = 1'b0;
        w_illegal = 1'b0;
        if (r_primed) begin
            case ({r_prev_ab, w_cur_ab})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: w_inc     = 1'b1;
                4'b0001, 4'b0111, 4'b1110, 4'b1000: w_dec     = 1'b1;
                4'b0011, 4'b1100, 4'b0110, 4'b1001: w_illegal = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_acc_next = r_acc;
        if (w_inc && (r_acc != ACC_MAX)) begin
            w_acc_next = r_acc + ACC_ONE;
        end else if (w_dec && (r_acc != ACC_MIN)) begin
            w_acc_next = r_acc - ACC_ONE;
        end
    end

    always_comb begin
        w_speed_clamped = w_acc_next[7:0];
        if (w_acc_next > CLAMP_HI) begin
            w_speed_clamped = 8'sd127;
        end else if (w_acc_next < CLAMP_LO) begin
            w_speed_clamped = -8'sd127;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_meta      <= 1'b0;
            r_a_sync      <= 1'b0;
            r_b_meta      <= 1'b0;
            r_b_sync      <= 1'b0;
            r_prev_ab     <= 2'b00;
            r_primed      <= 1'b0;
            r_acc         <= '0;
            r_win         <= '0;
            r_glitch_seen <= 1'b0;
            measuredSpeed <= '0;
            speedValid    <= 1'b0;
            glitch        <= 1'b0;
        end else begin
            r_a_meta   <= encA;
            r_a_sync   <= r_a_meta;
            r_b_meta   <= encB;
            r_b_sync   <= r_b_meta;
            r_prev_ab  <= w_cur_ab;
            r_primed   <= 1'b1;
            r_win      <= r_win + WINDOW_BITS'(1);
            speedValid <= w_eow;
            if (w_eow) begin
                // Boundary-cycle step belongs to the closing window only.
                measuredSpeed <= w_speed_clamped;
                glitch        <= r_glitch_seen | w_illegal;
                r_glitch_seen <= 1'b0;
                r_acc         <= '0;
            end else begin
                r_acc         <= w_acc_next;
                r_glitch_seen <= r_glitch_seen | w_illegal;
            end
        end
    end

endmodule

// File: tb/tb_quad_speed.sv
module tb_quad_speed;

    logic              clk;
    logic              reset_n;
    logic              encA;
    logic              encB;
    logic signed [7:0] measuredSpeed;
    logic              speedValid;
    logic              glitch;

    logic              enc2A;
    logic              enc2B;
    logic signed [7:0] measuredSpeed2;
    logic              speedValid2;
    logic              glitch2;

    int checks;
    int errors;
    logic [1:0] ph2;

    quad_speed #(.WINDOW_BITS(4), .ACC_BITS(16)) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .encA          (encA),
        .encB          (encB),
        .measuredSpeed (measuredSpeed),
        .speedValid    (speedValid),
        .glitch        (glitch)
    );

    quad_speed #(.WINDOW_BITS(10), .ACC_BITS(16)) u_dut10 (
        .clk           (clk),
        .reset_n       (reset_n),
        .encA          (enc2A),
        .encB          (enc2B),
        .measuredSpeed (measuredSpeed2),
        .speedValid    (speedValid2),
        .glitch        (glitch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    // Counts falling edges until speedValid is seen (bounded) and checks the count.
    task automatic wait_valid(input int exp_n, input string tag);
        int  n;
        bit  seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            seen = speedValid;
        end
        checks++;
        assert (n === exp_n) else begin
            errors++;
            $error("FAIL %s valid after %0d cycles expected %0d", tag, n, exp_n);
        end
    endtask

    // Drive A/B then hold for two clocks.
    task automatic step_to(input logic a, input logic b);
        encA = a;
        encB = b;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [1:0] gray(input logic [1:0] p);
        case (p)
            2'd0:    gray = 2'b00;
            2'd1:    gray = 2'b10;
            2'd2:    gray = 2'b11;
            default: gray = 2'b01;
        endcase
    endfunction

    initial begin
        int n;
        bit seen;
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        encA    = 1'b0;
        encB    = 1'b0;
        enc2A   = 1'b0;
        enc2B   = 1'b0;
        ph2     = 2'd0;

        repeat (3) @(negedge clk);
        chk("rst_speed", measuredSpeed, 8'h00);
        chk("rst_valid", {7'b0, speedValid}, 8'h00);
        chk("rst_glitch", {7'b0, glitch}, 8'h00);

        // Idle windows after release.
        reset_n = 1'b1;
        wait_valid(16, "first_valid");
        chk("idle_speed", measuredSpeed, 8'h00);
        chk("idle_glitch", {7'b0, glitch}, 8'h00);
        @(negedge clk);
        chk("valid_one_cycle", {7'b0, speedValid}, 8'h00);
        wait_valid(15, "idle_period");
        chk("idle2_speed", measuredSpeed, 8'h00);

        // Five forward steps.
        step_to(1'b1, 1'b0);
        step_to(1'b1, 1'b1);
        step_to(1'b0, 1'b1);
        step_to(1'b0, 1'b0);
        step_to(1'b1, 1'b0);
        wait_valid(6, "fwd_period");
        chk("fwd5_speed", measuredSpeed, 8'h05);
        chk("fwd5_glitch", {7'b0, glitch}, 8'h00);
        wait_valid(16, "fwd_idle_period");
        chk("fwd_idle_speed", measuredSpeed, 8'h00);

        // Three reverse steps from 10.
        step_to(1'b0, 1'b0);
        step_to(1'b0, 1'b1);
        step_to(1'b1, 1'b1);
        wait_valid(10, "rev_period");
        chk("rev3_speed", measuredSpeed, 8'hFD);

        // One forward step then an illegal 01->10 jump.
        step_to(1'b0, 1'b1);
        step_to(1'b1, 1'b0);
        wait_valid(12, "glitch_period");
        chk("glitch_speed", measuredSpeed, 8'h01);
        chk("glitch_set", {7'b0, glitch}, 8'h01);
        @(negedge clk);
        chk("glitch_held", {7'b0, glitch}, 8'h01);
        wait_valid(15, "clean_period");
        chk("clean_speed", measuredSpeed, 8'h00);
        chk("glitch_cleared", {7'b0, glitch}, 8'h00);

        // Step 10->11 arriving on the all-ones cycle of the window.
        repeat (13) @(negedge clk);
        encA = 1'b1;
        encB = 1'b1;
        wait_valid(3, "boundary_period");
        chk("boundary_closing", measuredSpeed, 8'h01);
        wait_valid(16, "boundary_next_period");
        chk("boundary_next", measuredSpeed, 8'h00);

        // Two forward steps so measuredSpeed is nonzero before the reset test.
        step_to(1'b0, 1'b1);
        step_to(1'b0, 1'b0);
        wait_valid(12, "pre_reset_period");
        chk("pre_reset_speed", measuredSpeed, 8'h02);

        // Four forward steps plus an illegal jump, then reset mid-window.
        step_to(1'b1, 1'b0);
        step_to(1'b1, 1'b1);
        step_to(1'b0, 1'b1);
        step_to(1'b0, 1'b0);
        encA = 1'b1;
        encB = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_speed", measuredSpeed, 8'h00);
        chk("midrst_valid", {7'b0, speedValid}, 8'h00);
        chk("midrst_glitch", {7'b0, glitch}, 8'h00);
        encA = 1'b0;
        encB = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_valid(16, "post_reset_valid");
        chk("post_reset_speed", measuredSpeed, 8'h00);
        chk("post_reset_glitch", {7'b0, glitch}, 8'h00);

        // 1024-cycle window instance: forward every 2 cycles clamps to +127.
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 2200) begin
            ph2 = ph2 + 2'd1;
            {enc2A, enc2B} = gray(ph2);
            repeat (2) begin
                @(negedge clk);
                n++;
                if (speedValid2) seen = 1'b1;
            end
        end
        chk("w10_fwd_valid_seen", {7'b0, seen}, 8'h01);
        chk("w10_fwd_clamp", measuredSpeed2, 8'h7F);
        chk("w10_fwd_glitch", {7'b0, glitch2}, 8'h00);

        // Reverse for a whole window clamps to -127, never -128.
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 2200) begin
            ph2 = ph2 - 2'd1;
            {enc2A, enc2B} = gray(ph2);
            repeat (2) begin
                @(negedge clk);
                n++;
                if (speedValid2) seen = 1'b1;
            end
        end
        chk("w10_rev_valid_seen", {7'b0, seen}, 8'h01);
        chk("w10_rev_clamp", measuredSpeed2, 8'h81);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quad_speed.md
QUAD_SPEED -- requirements
Module: quad_speed

Interface
REQ-001 SHALL have parameter WINDOW_BITS, default 20, giving a measurement window of 2^WINDOW_BITS clk cycles (about 21 ms at 50 MHz).
REQ-002 SHALL have parameter ACC_BITS, default 16, giving the signed accumulator width.
REQ-003 SHALL have port clk, input, 1 bit: 50 MHz clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port encA, input, 1 bit: quadrature channel A, asynchronous to clk.
REQ-006 SHALL have port encB, input, 1 bit: quadrature channel B, asynchronous to clk.
REQ-007 SHALL have port measuredSpeed, output, 8 bits, signed: encoder ticks per window, registered, feeding the P-controller's measuredSpeed input.
REQ-008 SHALL have port speedValid, output, 1 bit: one-cycle pulse when measuredSpeed updates.
REQ-009 SHALL have port glitch, output, 1 bit: high for the whole window after any window that saw an illegal transition.

Function
REQ-010 SHALL pass encA and encB each through a 2-flop synchronizer before use; decode latency is 2 clk from pin to synchronized value.
REQ-011 SHALL keep prevAB, the last synchronized {encA,encB}, plus a primed flag; the first synchronized sample after reset only loads prevAB and sets primed, with no count.
REQ-012 SHALL decode forward (+1) for {A,B} transitions 00->10, 10->11, 11->01 and 01->00.
REQ-013 SHALL decode reverse (-1) for {A,B} transitions 00->01, 01->11, 11->10 and 10->00.
REQ-014 SHALL decode prevAB equal to current as 0 with no flag.
REQ-015 SHALL treat a change of both bits in one cycle as illegal: count 0 and set the internal glitchSeen flag.
REQ-016 SHALL add the decoded step to a signed ACC_BITS accumulator that saturates at +(2^(ACC_BITS-1)-1) and -(2^(ACC_BITS-1)-1) and never wraps.
REQ-017 SHALL run a free-running unsigned WINDOW_BITS window counter that wraps from all-ones to 0.
REQ-018 SHALL, on the cycle the window counter equals all-ones, register measuredSpeed from the accumulator value including that cycle's step.
REQ-019 SHALL clamp that registered value to [-127,+127], so -128 is never produced, matching the controller's goal range.
REQ-020 SHALL, at that end-of-window cycle, pulse speedValid high for exactly that one cycle.
REQ-021 SHALL, at that end-of-window cycle, copy glitchSeen (including that cycle's event) to glitch and clear glitchSeen.
REQ-022 SHALL, at that end-of-window cycle, load the accumulator with 0, not with the step, so a step on the boundary cycle is counted only in the closing window.
REQ-023 SHALL hold measuredSpeed and glitch constant between end-of-window cycles.
REQ-024 SHALL have no combinational path from any input to any output.

Reset
REQ-025 SHALL, while reset_n is low, immediately clear measuredSpeed, speedValid, glitch, glitchSeen, the accumulator, the window counter, the synchronizers, prevAB and primed.
REQ-026 SHALL resume counting on the first clk edge after reset_n is released; the first speedValid occurs 2^WINDOW_BITS cycles after release.
REQ-027 SHALL, on reset asserted mid-window, discard partial counts and emit no speedValid for the interrupted window.

Verification (WINDOW_BITS=4, 16-cycle window)
REQ-028 SHALL cover: release reset with encA=encB=0 static -> speedValid every 16 cycles, measuredSpeed=0, glitch=0.
REQ-029 SHALL cover: 5 forward steps (00,10,11,01,00,10), one per 2 cycles, within a window -> measuredSpeed=+5 at the next speedValid, then 0 in the following idle window.
REQ-030 SHALL cover: 3 reverse steps in one window -> measuredSpeed=-3 (8'hFD).
REQ-031 SHALL cover: WINDOW_BITS=10 with forward steps every 2 cycles (about 512 steps) -> measuredSpeed=+127 clamped, with no wrap to negative.
REQ-032 SHALL cover: 00->11 applied directly -> accumulator unchanged, glitch=1 for exactly one window, then 0 after a clean window.
REQ-033 SHALL cover: a step landing on the window's all-ones cycle -> counted in the closing window only; and reset_n pulsed low mid-window with 4 steps pending -> all outputs 0, next speedValid 16 cycles after release.
